pool3_max_unit: RTL and testbench

Max-pooling stage directly downstream of the conv3 output buffer. It consumes the buffer's 2x2 window stream, where each window is four consecutive words and each word carries channel_num packed 16-bit lanes. For every window it emits one word holding the per-channel signed maximum, optionally clamped at zero. It tracks the window position within the pooled feature map and flags frame completion and protocol errors.

---
 rtl/pool3_pkg.sv | 19 +
 rtl/pool3_max_unit_if.sv | 27 ++
 rtl/pool3_lane_max.sv | 35 +++
 rtl/pool3_max_unit.sv | 99 +++++++++
 tb/tb_pool3_max_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool3_pkg.sv
// Shared packing definitions for the conv3 buffer, the pooling stage and later stages.
package pool3_pkg;
  localparam int bits          = 16;
  localparam int bits_shift    = 4;
  localparam int channel_num   = 16;
  localparam int window_size   = 4;
  localparam int window_size_2 = 2;
  localparam int bus_w         = channel_num << bits_shift;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Lane k of a packed word.
  function automatic logic [bits-1:0] lane_get(input logic [bus_w-1:0] word, input int k);
    return word[k*bits +: bits];
  endfunction
endpackage

// File: rtl/pool3_max_unit_if.sv
// Window stream in, pooled word plus position/status out.
interface pool3_max_unit_if #(
  parameter int col_w = 4,
  parameter int row_w = 5
) ();
  import pool3_pkg::*;

  logic             in_valid;
  logic             in_first;
  logic [bus_w-1:0] data_in;
  logic [bus_w-1:0] data_out;
  logic             out_valid;
  logic [col_w-1:0] out_col;
  logic [row_w-1:0] out_row;
  logic             frame_done;
  logic             err_sync;

  modport master (
    output in_valid, in_first, data_in,
    input  data_out, out_valid, out_col, out_row, frame_done, err_sync
  );

  modport slave (
    input  in_valid, in_first, data_in,
    output data_out, out_valid, out_col, out_row, frame_done, err_sync
  );
endinterface

// File: rtl/pool3_lane_max.sv
// One lane: running signed max over a window, optional zero clamp on the output word.
module pool3_lane_max
  import pool3_pkg::*;
#(
  parameter bit relu_en = 1'b0
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            load,
  input  logic            update,
  input  logic            close,
  input  logic [bits-1:0] lane_in,
  output logic [bits-1:0] lane_out
);
  logic signed [bits-1:0] acc;
  logic signed [bits-1:0] cand;
  logic signed [bits-1:0] best;

  // Ties keep the accumulator value.
  assign cand = lane_in;
  assign best = (cand > acc) ? cand : acc;

  // Accumulator: element 0 loads, later elements fold in the max.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (load)   acc <= cand;
    else if (update) acc <= best;
  end

  // Output word register; the clamp lives only here so the accumulator stays exact.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)     lane_out <= '0;
    else if (close) lane_out <= (relu_en && best[bits-1]) ? '0 : best;
  end
endmodule

// File: rtl/pool3_max_unit.sv
// 2x2 max-pool stage: window FSM, element count, feature-map position and error flag.
module pool3_max_unit
  import pool3_pkg::*;
#(
  parameter int out_length   = 8,
  parameter int out_length_2 = 4,
  parameter int out_height   = 28,
  parameter int out_height_2 = 5,
  parameter bit relu_en      = 1'b0
) (
  input logic             clk_in,
  input logic             rst_n,
  pool3_max_unit_if.slave bus
);
  state_t                   state, state_nxt;
  logic [window_size_2-1:0] elem_cnt;
  logic [out_length_2-1:0]  col;
  logic [out_height_2-1:0]  row;
  logic                     load, update, close, err_set;
  logic                     col_last, last_win;

  assign col_last = (col == out_length_2'(out_length - 1));
  assign last_win = col_last && (row == out_height_2'(out_height - 1));

  // State register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a premature in_first keeps us in ACC with a fresh window.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load)  state_nxt = ACC;
      ACC:     if (close) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from state and the input qualifiers.
  always_comb begin
    load    = bus.in_valid && bus.in_first;
    update  = (state == ACC) && bus.in_valid && !bus.in_first;
    close   = update && (elem_cnt == window_size_2'(window_size - 1));
    err_set = bus.in_valid && ((state == IDLE) ? !bus.in_first : bus.in_first);
  end

  // Element counter; element 0 counts as one.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)      elem_cnt <= '0;
    else if (load)   elem_cnt <= window_size_2'(1);
    else if (close)  elem_cnt <= '0;
    else if (update) elem_cnt <= elem_cnt + 1'b1;
  end

  // Position counters plus registered strobes; out_col/out_row latch the closing window's coordinates.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.out_col    <= '0;
      bus.out_row    <= '0;
    end else begin
      bus.out_valid  <= close;
      bus.frame_done <= close && last_win;
      if (close) begin
        bus.out_col <= col;
        bus.out_row <= row;
        if (col_last) begin
          col <= '0;
          row <= last_win ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)       bus.err_sync <= 1'b0;
    else if (err_set) bus.err_sync <= 1'b1;
  end

  for (genvar g = 0; g < channel_num; g++) begin : g_lane
    pool3_lane_max #(.relu_en(relu_en)) u_lane (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .load     (load),
      .update   (update),
      .close    (close),
      .lane_in  (lane_get(bus.data_in, g)),
      .lane_out (bus.data_out[g*bits +: bits])
    );
  end
endmodule

// File: tb/tb_pool3_max_unit.sv
// Directed bench for pool3_max_unit: one plain instance and one with the zero clamp.
module tb_pool3_max_unit;
  import pool3_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_first = 1'b0;
  logic [bus_w-1:0] data_in  = '0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int frames = 0;

  always #5 clk_in = ~clk_in;

  pool3_max_unit_if #(.col_w(4), .row_w(5)) bus0 ();
  pool3_max_unit_if #(.col_w(4), .row_w(5)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_first = in_first;
  assign bus0.data_in  = data_in;
  assign bus1.in_valid = in_valid;
  assign bus1.in_first = in_first;
  assign bus1.data_in  = data_in;

  pool3_max_unit #(.relu_en(1'b0)) u_dut      (.clk_in(clk_in), .rst_n(rst_n), .bus(bus0));
  pool3_max_unit #(.relu_en(1'b1)) u_dut_relu (.clk_in(clk_in), .rst_n(rst_n), .bus(bus1));

  // Pulse counters sampled mid-cycle.
  always @(negedge clk_in) begin
    if (bus0.out_valid)  pulses++;
    if (bus0.frame_done) frames++;
  end

  function automatic logic [bus_w-1:0] fill(input logic [15:0] v);
    logic [bus_w-1:0] w;
    for (int k = 0; k < channel_num; k++) w[k*bits +: bits] = v;
    return w;
  endfunction

  task automatic send(input logic f, input logic [bus_w-1:0] w);
    in_valid = 1'b1;
    in_first = f;
    data_in  = w;
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_win(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    send(1'b1, fill(a));
    send(1'b0, fill(b));
    send(1'b0, fill(c));
    send(1'b0, fill(d));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus0.data_out !== '0 || bus1.data_out !== '0) begin
      errors++; $display("FAIL reset_data got %h / %h want 0", bus0.data_out, bus1.data_out);
    end
    checks++;
    if ({bus0.out_valid, bus0.frame_done, bus0.err_sync, bus0.out_col, bus0.out_row} !== 12'h0) begin
      errors++; $display("FAIL reset_flags got v%b f%b e%b c%0d r%0d want all 0",
        bus0.out_valid, bus0.frame_done, bus0.err_sync, bus0.out_col, bus0.out_row);
    end
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_single();
    logic [bus_w-1:0] w0, w1, w2, w3, exp;
    for (int k = 0; k < channel_num; k++) begin
      w0[k*bits +: bits]  = 16'(k);
      w1[k*bits +: bits]  = 16'(0 - k);
      w2[k*bits +: bits]  = 16'(3 * k);
      w3[k*bits +: bits]  = 16'd2;
      exp[k*bits +: bits] = (k == 0) ? 16'd2 : 16'(3 * k);
    end
    send(1'b1, w0);
    send(1'b0, w1);
    send(1'b0, w2);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early_valid got %b want 0", bus0.out_valid);
    end
    send(1'b0, w3);
    checks++;
    if ({bus0.out_valid, bus0.out_col, bus0.out_row} !== {1'b1, 4'd0, 5'd0}) begin
      errors++; $display("FAIL single_valid_pos got v%b c%0d r%0d want v1 c0 r0", bus0.out_valid, bus0.out_col, bus0.out_row);
    end
    checks++;
    if (bus0.data_out !== exp || bus1.data_out !== exp) begin
      errors++; $display("FAIL single_data got %h / %h want %h", bus0.data_out, bus1.data_out, exp);
    end
    idle(1);
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.data_out !== exp) begin
      errors++; $display("FAIL single_hold got v%b %h want v0 %h", bus0.out_valid, bus0.data_out, exp);
    end
  endtask

  task automatic test_negative();
    send_win(16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFC);
    checks++;
    if (bus0.data_out !== fill(16'hFFFD)) begin
      errors++; $display("FAIL neg_plain got %h want %h", bus0.data_out, fill(16'hFFFD));
    end
    checks++;
    if (bus1.data_out !== '0) begin
      errors++; $display("FAIL neg_relu got %h want 0", bus1.data_out);
    end
    checks++;
    if (bus0.out_col !== 4'd1) begin
      errors++; $display("FAIL neg_col got %0d want 1", bus0.out_col);
    end
  endtask

  task automatic test_boundary();
    send_win(16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF);
    checks++;
    if (bus0.data_out !== fill(16'h7FFF) || bus1.data_out !== fill(16'h7FFF)) begin
      errors++; $display("FAIL boundary_data got %h / %h want %h", bus0.data_out, bus1.data_out, fill(16'h7FFF));
    end
    checks++;
    if (bus0.err_sync !== 1'b0 || bus0.out_col !== 4'd2) begin
      errors++; $display("FAIL boundary_state got e%b c%0d want e0 c2", bus0.err_sync, bus0.out_col);
    end
  endtask

  task automatic test_error();
    send(1'b1, fill(16'h7000));
    send(1'b0, fill(16'h7000));
    send(1'b1, fill(16'h0001));
    checks++;
    if (bus0.err_sync !== 1'b1 || bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart_err got e%b v%b want e1 v0", bus0.err_sync, bus0.out_valid);
    end
    send(1'b0, fill(16'h0005));
    send(1'b0, fill(16'h0002));
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart_early_valid got %b want 0", bus0.out_valid);
    end
    send(1'b0, fill(16'h0003));
    checks++;
    if ({bus0.out_valid, bus0.out_col} !== {1'b1, 4'd3} || bus0.data_out !== fill(16'h0005)) begin
      errors++; $display("FAIL restart_window got v%b c%0d %h want v1 c3 %h",
        bus0.out_valid, bus0.out_col, bus0.data_out, fill(16'h0005));
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, fill(16'h7000));
    send(1'b0, fill(16'h7000));
    send(1'b0, fill(16'h7000));
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus0.data_out !== '0 || bus1.data_out !== '0 ||
        {bus0.out_valid, bus0.frame_done, bus0.err_sync, bus0.out_col, bus0.out_row} !== 12'h0) begin
      errors++; $display("FAIL midreset_outputs got %h v%b e%b c%0d want all 0",
        bus0.data_out, bus0.out_valid, bus0.err_sync, bus0.out_col);
    end
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    send_win(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    checks++;
    if ({bus0.out_valid, bus0.out_col, bus0.out_row, bus0.err_sync} !== {1'b1, 4'd0, 5'd0, 1'b0} ||
        bus0.data_out !== fill(16'h0004)) begin
      errors++; $display("FAIL midreset_window got v%b c%0d r%0d e%b %h want v1 c0 r0 e0 %h",
        bus0.out_valid, bus0.out_col, bus0.out_row, bus0.err_sync, bus0.data_out, fill(16'h0004));
    end
    send(1'b0, fill(16'h0009));
    checks++;
    if (bus0.err_sync !== 1'b1 || bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL stray_idle got e%b v%b want e1 v0", bus0.err_sync, bus0.out_valid);
    end
  endtask

  // Full 8x28 frame; max_gap=0 is back-to-back.
  task automatic run_frame(input string name, input int max_gap);
    int p0, f0;
    logic [3:0]  ec;
    logic [4:0]  er;
    logic [15:0] ev;
    p0 = pulses;
    f0 = frames;
    for (int i = 0; i < 224; i++) begin
      ec = 4'(i % 8);
      er = 5'(i / 8);
      ev = (i == 0) ? 16'd1 : 16'(i);
      idle($urandom_range(max_gap, 0));
      send(1'b1, fill(16'h0000));
      idle($urandom_range(max_gap, 0));
      send(1'b0, fill(16'(i)));
      idle($urandom_range(max_gap, 0));
      send(1'b0, fill(16'hFFFF));
      idle($urandom_range(max_gap, 0));
      send(1'b0, fill(16'h0001));
      checks++;
      if ({bus0.out_valid, bus0.frame_done, bus0.out_col, bus0.out_row} !== {1'b1, (i == 223), ec, er}) begin
        errors++; $display("FAIL %s_pos[%0d] got v%b f%b c%0d r%0d want v1 f%b c%0d r%0d", name, i,
          bus0.out_valid, bus0.frame_done, bus0.out_col, bus0.out_row, (i == 223), ec, er);
      end
      checks++;
      if (bus0.data_out !== fill(ev)) begin
        errors++; $display("FAIL %s_data[%0d] got %h want %h", name, i, bus0.data_out, fill(ev));
      end
    end
    idle(2);
    checks++;
    if (pulses - p0 != 224 || frames - f0 != 1) begin
      errors++; $display("FAIL %s_counts got %0d pulses %0d frames want 224 1", name, pulses - p0, frames - f0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame("b2b", 0);
  endtask

  task automatic test_gaps();
    run_frame("gaps", 3);
    send_win(16'h0002, 16'h0001, 16'h0001, 16'h0001);
    checks++;
    if ({bus0.out_valid, bus0.frame_done, bus0.out_col, bus0.out_row} !== {1'b1, 1'b0, 4'd0, 5'd0}) begin
      errors++; $display("FAIL wrap_pos got v%b f%b c%0d r%0d want v1 f0 c0 r0",
        bus0.out_valid, bus0.frame_done, bus0.out_col, bus0.out_row);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_negative();
    test_boundary();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
